bank_miss_queue: RTL and testbench

Per-bank miss queue sitting directly downstream of the tag-access stage: every lookup that returns `tag_match = 0` is enqueued here with its request metadata until the memory fill for that line arrives, then replayed into the bank pipeline in allocation order. It also reports whether a miss hits a line already outstanding, so the bank issues only one memory request per line. Fills seen here are the same fills written into the tag store.

---
 rtl/bank_miss_queue_pkg.sv | 17 +
 rtl/bank_miss_queue_if.sv | 33 +++
 rtl/bank_miss_queue_mshr_addr_cam.sv | 22 ++
 rtl/bank_miss_queue.sv | 118 +++++++++++
 tb/tb_bank_miss_queue.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/bank_miss_queue_pkg.sv
// Shared definitions for the per-bank miss queue: default sizes and the
// logical layout of one outstanding-miss entry.
package bank_miss_queue_pkg;

  localparam int LINE_ADDR_W     = 26;
  localparam int DATA_W          = 64;
  localparam int MSHR_ENTRIES    = 8;
  localparam int MSHR_ADDR_WIDTH = $clog2(MSHR_ENTRIES);

  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [LINE_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      data;
  } mshr_entry_t;

endpackage

// File: rtl/bank_miss_queue_if.sv
// Allocation, fill and replay signals between the bank pipeline and its miss queue.
interface bank_miss_queue_if
  import bank_miss_queue_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = LINE_ADDR_W,
  parameter int DATA_WIDTH      = DATA_W,
  parameter int ID_WIDTH        = MSHR_ADDR_WIDTH
);
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [LINE_ADDR_WIDTH-1:0] alloc_addr;
  logic [DATA_WIDTH-1:0]      alloc_data;
  logic [ID_WIDTH-1:0]        alloc_id;
  logic                       alloc_pending;
  logic                       fill_valid;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr;
  logic                       deq_valid;
  logic                       deq_ready;
  logic [LINE_ADDR_WIDTH-1:0] deq_addr;
  logic [DATA_WIDTH-1:0]      deq_data;
  logic                       empty;
  logic                       full;

  modport master (
    output alloc_valid, alloc_addr, alloc_data, fill_valid, fill_addr, deq_ready,
    input  alloc_ready, alloc_id, alloc_pending, deq_valid, deq_addr, deq_data, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_data, fill_valid, fill_addr, deq_ready,
    output alloc_ready, alloc_id, alloc_pending, deq_valid, deq_addr, deq_data, empty, full
  );
endinterface

// File: rtl/bank_miss_queue_mshr_addr_cam.sv
// Parallel address compare across all queue entries. With SKIP_READY set,
// entries whose fill already arrived are excluded (used for the pending check).
module mshr_addr_cam #(
  parameter int ENTRIES    = 8,
  parameter int ADDR_WIDTH = 26,
  parameter bit SKIP_READY = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i [ENTRIES],
  input  logic [ENTRIES-1:0]    valid_i,
  input  logic [ENTRIES-1:0]    ready_i,
  input  logic [ADDR_WIDTH-1:0] query_i,
  output logic [ENTRIES-1:0]    match_o
);

  always_comb begin
    match_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match_o[i] = valid_i[i] && !(SKIP_READY && ready_i[i]) && (addr_i[i] == query_i);
    end
  end

endmodule

// File: rtl/bank_miss_queue.sv
// Per-bank miss queue: holds missed requests until their line is filled,
// reports already-outstanding lines, and replays strictly in allocation order.
module bank_miss_queue
  import bank_miss_queue_pkg::*;
#(
  parameter int LINE_ADDR_WIDTH = LINE_ADDR_W,
  parameter int MSHR_SIZE       = MSHR_ENTRIES,
  parameter int DATA_WIDTH      = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  bank_miss_queue_if.slave  bus
);

  localparam int AW = $clog2(MSHR_SIZE);

  logic [MSHR_SIZE-1:0]       valid_q, valid_d;
  logic [MSHR_SIZE-1:0]       ready_q, ready_d;
  logic [LINE_ADDR_WIDTH-1:0] addr_q [MSHR_SIZE];
  logic [DATA_WIDTH-1:0]      data_q [MSHR_SIZE];
  logic [AW-1:0]              head_q, head_d;
  logic [AW-1:0]              tail_q, tail_d;
  logic [AW:0]                count_q, count_d;

  logic [MSHR_SIZE-1:0] allocMatch;
  logic [MSHR_SIZE-1:0] fillMatch;
  logic                 fullFlag;
  logic                 deqValid;
  logic                 allocFire;
  logic                 deqFire;
  logic                 allocSameFill;

  mshr_addr_cam #(
    .ENTRIES    (MSHR_SIZE),
    .ADDR_WIDTH (LINE_ADDR_WIDTH),
    .SKIP_READY (1'b1)
  ) u_alloc_cam (
    .addr_i  (addr_q),
    .valid_i (valid_q),
    .ready_i (ready_q),
    .query_i (bus.alloc_addr),
    .match_o (allocMatch)
  );

  mshr_addr_cam #(
    .ENTRIES    (MSHR_SIZE),
    .ADDR_WIDTH (LINE_ADDR_WIDTH),
    .SKIP_READY (1'b0)
  ) u_fill_cam (
    .addr_i  (addr_q),
    .valid_i (valid_q),
    .ready_i (ready_q),
    .query_i (bus.fill_addr),
    .match_o (fillMatch)
  );

  // alloc_ready comes from the registered count only, so a full queue refuses
  // an enqueue even when the head leaves in the same cycle.
  assign fullFlag      = (count_q == (AW+1)'(MSHR_SIZE));
  assign deqValid      = valid_q[head_q] && ready_q[head_q];
  assign allocFire     = bus.alloc_valid && !fullFlag;
  assign deqFire       = deqValid && bus.deq_ready;
  assign allocSameFill = bus.fill_valid && (bus.fill_addr == bus.alloc_addr);

  assign bus.alloc_ready   = !fullFlag;
  assign bus.alloc_id      = tail_q;
  assign bus.alloc_pending = (|allocMatch) || allocSameFill;
  assign bus.deq_valid     = deqValid;
  assign bus.deq_addr      = addr_q[head_q];
  assign bus.deq_data      = data_q[head_q];
  assign bus.empty         = (count_q == '0);
  assign bus.full          = fullFlag;

  // The dequeue is applied after the fill so a head that is filled and
  // replayed in the same cycle ends up freed rather than left ready.
  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q | (bus.fill_valid ? fillMatch : '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (AW+1)'(allocFire) - (AW+1)'(deqFire);
    if (allocFire) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = allocSameFill;
      tail_d          = tail_q + AW'(1);
    end
    if (deqFire) begin
      valid_d[head_q] = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (allocFire) begin
      addr_q[tail_q] <= bus.alloc_addr;
      data_q[tail_q] <= bus.alloc_data;
    end
  end

endmodule

// File: tb/tb_bank_miss_queue.sv
// Randomized and directed bench for bank_miss_queue against an in-order
// queue model of outstanding misses.
module tb_bank_miss_queue;
  import bank_miss_queue_pkg::*;

  logic clk;
  logic reset;

  bank_miss_queue_if #(
    .LINE_ADDR_WIDTH (LINE_ADDR_W),
    .DATA_WIDTH      (DATA_W),
    .ID_WIDTH        (MSHR_ADDR_WIDTH)
  ) bus ();

  bank_miss_queue #(
    .LINE_ADDR_WIDTH (LINE_ADDR_W),
    .MSHR_SIZE       (MSHR_ENTRIES),
    .DATA_WIDTH      (DATA_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mshr_entry_t model[$];
  int allocCount = 0;
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // One cycle: drive at the falling edge, check the pre-edge view, then advance the model.
  task automatic applyStimulus(input logic av, input logic [LINE_ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                               input logic fv, input logic [LINE_ADDR_W-1:0] fa, input logic dr);
    logic        expDeqValid;
    logic        expPending;
    logic        allocFire;
    logic        deqFire;
    mshr_entry_t newEntry;
    @(negedge clk);
    bus.alloc_valid = av;
    bus.alloc_addr  = aa;
    bus.alloc_data  = ad;
    bus.fill_valid  = fv;
    bus.fill_addr   = fa;
    bus.deq_ready   = dr;
    #1;
    expDeqValid = (model.size() > 0) && model[0].ready;
    checkOutput("alloc_ready", 64'(bus.alloc_ready), 64'(model.size() < MSHR_ENTRIES));
    checkOutput("alloc_id", 64'(bus.alloc_id), 64'(allocCount % MSHR_ENTRIES));
    checkOutput("empty", 64'(bus.empty), 64'(model.size() == 0));
    checkOutput("full", 64'(bus.full), 64'(model.size() == MSHR_ENTRIES));
    checkOutput("deq_valid", 64'(bus.deq_valid), 64'(expDeqValid));
    if (expDeqValid) begin
      checkOutput("deq_addr", 64'(bus.deq_addr), 64'(model[0].addr));
      checkOutput("deq_data", 64'(bus.deq_data), 64'(model[0].data));
    end
    if (av) begin
      expPending = fv && (fa == aa);
      foreach (model[i]) if (!model[i].ready && model[i].addr == aa) expPending = 1'b1;
      checkOutput("alloc_pending", 64'(bus.alloc_pending), 64'(expPending));
    end
    allocFire = av && (model.size() < MSHR_ENTRIES);
    deqFire   = dr && expDeqValid;
    if (fv) foreach (model[i]) if (model[i].addr == fa) model[i].ready = 1'b1;
    if (deqFire) void'(model.pop_front());
    if (allocFire) begin
      newEntry.valid = 1'b1;
      newEntry.ready = fv && (fa == aa);
      newEntry.addr  = aa;
      newEntry.data  = ad;
      model.push_back(newEntry);
      allocCount++;
    end
  endtask

  task automatic enq(input logic [LINE_ADDR_W-1:0] a);
    applyStimulus(1'b1, a, {$urandom, $urandom}, 1'b0, '0, 1'b0);
  endtask

  task automatic drainAll();
    for (int n = 0; n < 64 && model.size() > 0; n++)
      applyStimulus(1'b0, '0, '0, 1'b1, model[0].addr, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("drained_empty", 64'(bus.empty), 64'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_alloc_ready"}, 64'(bus.alloc_ready), 64'd1);
    checkOutput({tag, "_deq_valid"}, 64'(bus.deq_valid), 64'd0);
    checkOutput({tag, "_empty"}, 64'(bus.empty), 64'd1);
    checkOutput({tag, "_full"}, 64'(bus.full), 64'd0);
    checkOutput({tag, "_alloc_id"}, 64'(bus.alloc_id), 64'd0);
    checkOutput({tag, "_alloc_pending"}, 64'(bus.alloc_pending), 64'd0);
  endtask

  initial begin
    logic [LINE_ADDR_W-1:0] fa;
    reset = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_addr = '0; bus.alloc_data = '0;
    bus.fill_valid  = 1'b0; bus.fill_addr  = '0; bus.deq_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkResetValues("por");
    @(negedge clk) reset = 1'b1;

    // Same-line misses, blocked head, in-order replay
    enq(26'h10); enq(26'h20); enq(26'h10);
    applyStimulus(1'b0, '0, '0, 1'b1, 26'h10, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b1, 26'h20, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("order_empty", 64'(bus.empty), 64'd1);

    // Fill coinciding with enqueue into an empty queue
    applyStimulus(1'b1, 26'h30, 64'hA5A5, 1'b1, 26'h30, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

    // Fill to capacity, then enqueue+dequeue while full
    applyStimulus(1'b1, 26'h100, {$urandom, $urandom}, 1'b1, 26'h100, 1'b0);
    for (int i = 1; i < MSHR_ENTRIES; i++) enq(26'h100 + 26'(i));
    applyStimulus(1'b1, 26'h1FF, 64'hDEAD, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("after_full_full", 64'(bus.full), 64'd0);
    drainAll();

    // Wrap-around rounds
    for (int r = 0; r < 20; r++) begin
      enq(26'h200 + 26'(r));
      applyStimulus(1'b0, '0, '0, 1'b1, 26'h200 + 26'(r), 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
    checkOutput("wrap_empty", 64'(bus.empty), 64'd1);

    // Randomized traffic over a small address pool to provoke shared lines
    for (int n = 0; n < 400; n++) begin
      if (model.size() > 0 && $urandom_range(0, 1) == 1)
        fa = model[$urandom_range(0, model.size() - 1)].addr;
      else
        fa = 26'h40 + 26'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 6, 26'h40 + 26'($urandom_range(0, 7)), {$urandom, $urandom},
                    $urandom_range(0, 9) < 3, fa, $urandom_range(0, 9) < 7);
    end
    drainAll();

    // Asynchronous reset with five entries held
    applyStimulus(1'b1, 26'h300, 64'h1, 1'b1, 26'h300, 1'b0);
    for (int i = 1; i < 5; i++) enq(26'h300 + 26'(i));
    @(negedge clk);
    bus.alloc_valid = 1'b0; bus.fill_valid = 1'b0; bus.deq_ready = 1'b0;
    bus.alloc_addr  = 26'h301;
    #1;
    checkOutput("pre_reset_pending", 64'(bus.alloc_pending), 64'd1);
    checkOutput("pre_reset_deq_valid", 64'(bus.deq_valid), 64'd1);
    #1 reset = 1'b0;
    #1 checkResetValues("async");
    model.delete();
    allocCount = 0;
    @(negedge clk) reset = 1'b1;
    applyStimulus(1'b1, 26'h55, 64'h77, 1'b1, 26'h55, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
